// File: rtl/peripherals.sv
// Shared peripheral types: the push-button bundle and the per-button debounce state.
package peripherals;

    typedef struct packed {
        logic left;
        logic right;
        logic up;
        logic down;
        logic center;
    } buttons_t;

    localparam int unsigned NUM_BUTTONS = $bits(buttons_t);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PENDING,
        PRESSED,
        RELEASE_PENDING
    } debounce_state_t;

endpackage

// File: rtl/button_debouncer.sv
// One push-button: synchroniser, debounce FSM and auto-repeat.
// Produces a clean level plus one-cycle press/release pulses.
module button_debouncer
    import peripherals::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYCLES  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 10_000_000,
    parameter int unsigned SYNC_STAGES          = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    input  logic i_repeat_enable,
    output logic o_level,
    output logic o_pressed,
    output logic o_released
);

    localparam int unsigned REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES)
                                    ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD_CYCLES - 1);
    localparam logic             DEB_SINGLE  = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    debounce_state_t        r_state;
    logic [DEB_W-1:0]       r_deb_cnt;
    logic [REP_W-1:0]       r_rep_cnt;
    logic                   r_repeating;
    logic                   r_level;
    logic                   r_pressed;
    logic                   r_released;
    logic [REP_W-1:0]       w_rep_last;

    // Metastability chain; only the last stage is observed.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_rep_last = r_repeating ? PERIOD_LAST : DELAY_LAST;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= RELEASED;
            r_deb_cnt   <= '0;
            r_rep_cnt   <= '0;
            r_repeating <= 1'b0;
            r_level     <= 1'b0;
            r_pressed   <= 1'b0;
            r_released  <= 1'b0;
        end else begin
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
            case (r_state)
                RELEASED: begin
                    if (w_sync) begin
                        if (DEB_SINGLE) begin
                            r_state     <= PRESSED;
                            r_level     <= 1'b1;
                            r_pressed   <= 1'b1;
                            r_rep_cnt   <= '0;
                            r_repeating <= 1'b0;
                            r_deb_cnt   <= '0;
                        end else begin
                            r_state   <= PRESS_PENDING;
                            r_deb_cnt <= DEB_W'(1);
                        end
                    end
                end

                PRESS_PENDING: begin
                    if (!w_sync) begin
                        r_state   <= RELEASED;
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt >= DEB_LAST) begin
                        r_state     <= PRESSED;
                        r_level     <= 1'b1;
                        r_pressed   <= 1'b1;
                        r_rep_cnt   <= '0;
                        r_repeating <= 1'b0;
                        r_deb_cnt   <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                    end
                end

                PRESSED: begin
                    if (!w_sync) begin
                        if (DEB_SINGLE) begin
                            r_state    <= RELEASED;
                            r_level    <= 1'b0;
                            r_released <= 1'b1;
                            r_deb_cnt  <= '0;
                        end else begin
                            r_state   <= RELEASE_PENDING;
                            r_deb_cnt <= DEB_W'(1);
                        end
                    end else if (!i_repeat_enable) begin
                        r_rep_cnt   <= '0;
                        r_repeating <= 1'b0;
                    end else if (r_rep_cnt >= w_rep_last) begin
                        // A pulse already high this cycle defers the repeat so pulses never merge.
                        if (!r_pressed) begin
                            r_pressed   <= 1'b1;
                            r_rep_cnt   <= '0;
                            r_repeating <= 1'b1;
                        end
                    end else begin
                        r_rep_cnt <= r_rep_cnt + REP_W'(1);
                    end
                end

                RELEASE_PENDING: begin
                    if (w_sync) begin
                        r_state     <= PRESSED;
                        r_rep_cnt   <= '0;
                        r_repeating <= 1'b0;
                        r_deb_cnt   <= '0;
                    end else if (r_deb_cnt >= DEB_LAST) begin
                        r_state    <= RELEASED;
                        r_level    <= 1'b0;
                        r_released <= 1'b1;
                        r_deb_cnt  <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                    end
                end

                default: begin
                    r_state <= RELEASED;
                end
            endcase
        end
    end

    assign o_level    = r_level;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the five raw push-buttons into clean levels and press/release events
// for peripheral_manager; one independent debouncer per button.
module button_conditioner
    import peripherals::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYCLES  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 10_000_000,
    parameter int unsigned SYNC_STAGES          = 2
) (
    input  logic     clock_100mhz,
    input  logic     reset,
    input  buttons_t raw_buttons,
    input  logic     repeat_enable,
    output buttons_t buttons_level,
    output buttons_t buttons_pressed,
    output buttons_t buttons_released
);

    logic [NUM_BUTTONS-1:0] w_raw;
    logic [NUM_BUTTONS-1:0] w_level;
    logic [NUM_BUTTONS-1:0] w_pressed;
    logic [NUM_BUTTONS-1:0] w_released;

    assign w_raw = raw_buttons;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_button
        button_debouncer #(
            .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
            .SYNC_STAGES          (SYNC_STAGES)
        ) u_debouncer (
            .i_clk           (clock_100mhz),
            .i_rst_n         (reset),
            .i_raw           (w_raw[g]),
            .i_repeat_enable (repeat_enable),
            .o_level         (w_level[g]),
            .o_pressed       (w_pressed[g]),
            .o_released      (w_released[g])
        );
    end

    assign buttons_level    = buttons_t'(w_level);
    assign buttons_pressed  = buttons_t'(w_pressed);
    assign buttons_released = buttons_t'(w_released);

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity,
// all compared every cycle against a run-length reference model.
module tb_button_conditioner;
    import peripherals::*;

    localparam int DEB    = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 3;
    localparam int NB     = 5;

    logic     clk = 1'b0;
    logic     rst_n;
    buttons_t raw_buttons;
    logic     repeat_enable;
    buttons_t buttons_level;
    buttons_t buttons_pressed;
    buttons_t buttons_released;

    logic [4:0] lvl_v, prs_v, rel_v;
    assign lvl_v = buttons_level;
    assign prs_v = buttons_pressed;
    assign rel_v = buttons_released;

    button_conditioner #(
        .DEBOUNCE_CYCLES      (DEB),
        .REPEAT_DELAY_CYCLES  (DELAY),
        .REPEAT_PERIOD_CYCLES (PERIOD),
        .SYNC_STAGES          (2)
    ) dut (
        .clock_100mhz     (clk),
        .reset            (rst_n),
        .raw_buttons      (raw_buttons),
        .repeat_enable    (repeat_enable),
        .buttons_level    (buttons_level),
        .buttons_pressed  (buttons_pressed),
        .buttons_released (buttons_released)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: raw delay line, mismatch run length, qualified-hold run length.
    logic [4:0] m_d1 = '0, m_d2 = '0, m_sync_prev = '0;
    logic [4:0] m_level = '0, m_pressed = '0, m_released = '0;
    int         m_mis[NB];
    int         m_run[NB];
    logic [4:0] prev_prs = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [4:0] raw, input logic en, input logic rst);
        logic [4:0] sync;
        if (!rst) begin
            m_d1 = '0; m_d2 = '0; m_sync_prev = '0;
            m_level = '0; m_pressed = '0; m_released = '0;
            for (int i = 0; i < NB; i++) begin
                m_mis[i] = 0;
                m_run[i] = 0;
            end
        end else begin
            sync = m_d2;
            m_pressed = '0;
            m_released = '0;
            for (int i = 0; i < NB; i++) begin
                logic lvl_before;
                lvl_before = m_level[i];
                // Repeats: DELAY qualifying holds for the first, then every PERIOD.
                if (lvl_before && sync[i] && m_sync_prev[i] && en) begin
                    m_run[i]++;
                    if (m_run[i] >= DELAY && ((m_run[i] - DELAY) % PERIOD) == 0)
                        m_pressed[i] = 1'b1;
                end else begin
                    m_run[i] = 0;
                end
                if (sync[i] != lvl_before) begin
                    m_mis[i]++;
                    if (m_mis[i] == DEB) begin
                        m_mis[i] = 0;
                        m_level[i] = sync[i];
                        if (sync[i]) m_pressed[i] = 1'b1;
                        else         m_released[i] = 1'b1;
                    end
                end else begin
                    m_mis[i] = 0;
                end
            end
            m_sync_prev = sync;
            m_d2 = m_d1;
            m_d1 = raw;
        end
    endtask

    task automatic step(input logic [4:0] raw, input logic en, input logic rst);
        raw_buttons   = buttons_t'(raw);
        repeat_enable = en;
        rst_n         = rst;
        @(posedge clk);
        model_edge(raw, en, rst);
        #1;
        chk("level",    32'(lvl_v), 32'(m_level));
        chk("pressed",  32'(prs_v), 32'(m_pressed));
        chk("released", 32'(rel_v), 32'(m_released));
        chk("press_release_overlap", 32'(prs_v & rel_v), 32'd0);
        chk("press_back_to_back",    32'(prs_v & prev_prs), 32'd0);
        prev_prs = prs_v;
    endtask

    task automatic check_events(input string tag, input int got[$], input int exp[$]);
        chk($sformatf("%s_count", tag), 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s_edge%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF,
                32'(exp[i]));
    endtask

    initial begin
        int ev[$];
        int rel[$];
        int exp_q[$];
        int rate;
        logic [4:0] rnd_raw;
        logic rnd_en;

        for (int i = 0; i < NB; i++) begin
            m_mis[i] = 0;
            m_run[i] = 0;
        end

        // Reset held with every button down: everything stays quiet.
        for (int k = 0; k < 10; k++) begin
            step(5'h1f, 1'b0, 1'b0);
            chk("rst_hold_outputs", 32'({lvl_v, prs_v, rel_v}), 32'd0);
        end
        ev.delete();
        for (int k = 1; k <= 8; k++) begin
            step(5'h1f, 1'b0, 1'b1);
            if (prs_v == 5'h1f) ev.push_back(k);
        end
        exp_q = {6};
        check_events("rst_exit_press", ev, exp_q);
        chk("rst_exit_level", 32'(lvl_v), 32'h1f);
        for (int k = 0; k < 10; k++) step(5'h00, 1'b0, 1'b1);

        // Bounce on center shorter than the debounce window.
        ev.delete();
        for (int k = 1; k <= 15; k++) begin
            step((k <= 3 || (k >= 5 && k <= 7)) ? 5'h01 : 5'h00, 1'b0, 1'b1);
            if (buttons_pressed.center || buttons_released.center) ev.push_back(k);
        end
        exp_q = {};
        check_events("bounce", ev, exp_q);
        chk("bounce_level", 32'(buttons_level.center), 32'd0);

        // Clean press and release on left, repeat disabled.
        ev.delete(); rel.delete();
        for (int k = 1; k <= 30; k++) begin
            step((k <= 20) ? 5'h10 : 5'h00, 1'b0, 1'b1);
            if (buttons_pressed.left)  ev.push_back(k);
            if (buttons_released.left) rel.push_back(k);
        end
        exp_q = {6};
        check_events("clean_press", ev, exp_q);
        exp_q = {26};
        check_events("clean_release", rel, exp_q);

        // Auto-repeat on up, paused between edges 20 and 27.
        ev.delete(); rel.delete();
        for (int k = 1; k <= 50; k++) begin
            step((k <= 40) ? 5'h04 : 5'h00, (k < 20 || k >= 28), 1'b1);
            if (buttons_pressed.up)  ev.push_back(k);
            if (buttons_released.up) rel.push_back(k);
        end
        exp_q = {6, 16, 19, 37, 40};
        check_events("repeat_press", ev, exp_q);
        exp_q = {46};
        check_events("repeat_release", rel, exp_q);

        // Short release glitch on right must not produce a release.
        ev.delete(); rel.delete();
        for (int k = 1; k <= 32; k++) begin
            step((k <= 10 || (k >= 13 && k <= 22)) ? 5'h08 : 5'h00, 1'b0, 1'b1);
            if (buttons_pressed.right)  ev.push_back(k);
            if (buttons_released.right) rel.push_back(k);
            if (k == 20) chk("glitch_level", 32'(buttons_level.right), 32'd1);
        end
        exp_q = {6};
        check_events("glitch_press", ev, exp_q);
        exp_q = {28};
        check_events("glitch_release", rel, exp_q);

        // Reset while down is still being debounced discards the press.
        ev.delete();
        for (int k = 1; k <= 4; k++) begin
            step(5'h02, 1'b0, (k != 4));
            if (buttons_pressed.down) ev.push_back(k);
        end
        for (int k = 1; k <= 10; k++) begin
            step(5'h02, 1'b0, 1'b1);
            if (buttons_pressed.down) ev.push_back(10 + k);
        end
        exp_q = {16};
        check_events("reset_mid_press", ev, exp_q);
        for (int k = 0; k < 10; k++) step(5'h00, 1'b0, 1'b1);

        // Random activity with varying bounce rates, repeat toggling and rare resets.
        rnd_raw = '0;
        rnd_en  = 1'b1;
        rate    = 8;
        for (int k = 0; k < 1200; k++) begin
            if (k % 60 == 0) rate = int'($urandom_range(3, 30));
            for (int b = 0; b < NB; b++)
                if ($urandom_range(rate - 1, 0) == 0) rnd_raw[b] = ~rnd_raw[b];
            if ($urandom_range(39, 0) == 0) rnd_en = ~rnd_en;
            step(rnd_raw, rnd_en, ($urandom_range(249, 0) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
